// File: rtl/fetch_predict.sv
// fetch_predict: RV32I fetch stage with PC, 2-bit BHT prediction and IF/ID register.
// Redirects that arrive while memory is stalled are parked in pend_pc so the fetch address stays stable.
module fetch_predict #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BHT_IDX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_stall,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ins,
  input  logic        i_br,
  input  logic [31:0] i_imm,
  input  logic        i_id_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_ex_upd,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  output logic        o_id_valid,
  output logic [31:0] o_id_ins,
  output logic [31:0] o_id_pc,
  output logic        o_id_pred_taken
);
  logic [31:0] pc, pend_pc, npc;
  logic pend, pred;
  logic [1:0] bht [2**BHT_IDX];
  logic [1:0] ctr, uctr;
  logic [BHT_IDX-1:0] ridx, uidx;
  always_comb begin
    ridx = pc[BHT_IDX+1:2];
    uidx = i_ex_pc[BHT_IDX+1:2];
    ctr  = bht[ridx];
    uctr = bht[uidx];
    pred = i_br && ctr[1];
    npc  = pc + (pred ? i_imm : 32'd4);
  end
  assign o_imem_addr = pc;
  assign o_ins = i_imem_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
      pend <= 1'b0;
      pend_pc <= 32'd0;
      o_imem_req <= 1'b0;
      o_id_valid <= 1'b0;
      o_id_ins <= 32'd0;
      o_id_pc <= 32'd0;
      o_id_pred_taken <= 1'b0;
      for (int i = 0; i < 2**BHT_IDX; i++) bht[i] <= 2'b01;
    end else begin
      o_imem_req <= 1'b1;
      if (i_ex_upd)
        bht[uidx] <= i_ex_taken ? (uctr == 2'b11 ? uctr : uctr + 2'd1)
                                : (uctr == 2'b00 ? uctr : uctr - 2'd1);
      if (i_redirect) begin
        o_id_valid <= 1'b0;
        if (i_imem_stall) begin
          pend_pc <= i_redirect_pc;
          pend <= 1'b1;
        end else begin
          pc <= i_redirect_pc;
          pend <= 1'b0;
        end
      end else if (pend) begin
        // the word returned alongside the parked redirect belongs to the old path
        if (!i_imem_stall) begin
          pc <= pend_pc;
          pend <= 1'b0;
          o_id_valid <= 1'b0;
        end
      end else if (!i_id_stall) begin
        if (i_imem_stall) o_id_valid <= 1'b0;
        else if (o_imem_req) begin
          pc <= npc;
          o_id_ins <= i_imem_rdata;
          o_id_pc <= pc;
          o_id_pred_taken <= pred;
          o_id_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_predict.sv
// tb_fetch_predict: directed scenario tests for fetch_predict with a simple instruction memory.
module tb_fetch_predict;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_stall;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_ins;
  logic        i_br;
  logic [31:0] i_imm;
  logic        i_id_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_ex_upd;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic        o_id_valid;
  logic [31:0] o_id_ins;
  logic [31:0] o_id_pc;
  logic        o_id_pred_taken;
  int checks = 0;
  int errors = 0;

  fetch_predict dut (
    .clk(clk), .rst_n(rst_n),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_stall(i_imem_stall), .i_imem_rdata(i_imem_rdata), .o_ins(o_ins),
    .i_br(i_br), .i_imm(i_imm), .i_id_stall(i_id_stall),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .i_ex_upd(i_ex_upd), .i_ex_pc(i_ex_pc), .i_ex_taken(i_ex_taken),
    .o_id_valid(o_id_valid), .o_id_ins(o_id_ins), .o_id_pc(o_id_pc),
    .o_id_pred_taken(o_id_pred_taken)
  );

  always #5 clk = ~clk;
  // memory returns a word tagged with its own address
  assign i_imem_rdata = 32'hC0DE_0000 ^ o_imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_imem_stall = 0; i_br = 0; i_imm = 32'd4; i_id_stall = 0;
    i_redirect = 0; i_redirect_pc = 0; i_ex_upd = 0; i_ex_pc = 0; i_ex_taken = 0;
    #3;
    checks++; if (o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 00000000", o_imem_addr); end
    checks++; if (o_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", o_id_valid); end
    checks++; if (o_id_ins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h exp 00000000", o_id_ins); end
    checks++; if (o_id_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 00000000", o_id_pc); end
    checks++; if (o_id_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b exp 0", o_id_pred_taken); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (o_imem_req !== 1'b1) begin errors++; $display("FAIL req_rise: got %b exp 1", o_imem_req); end
    checks++; if (o_imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr: got %h exp 00000000", o_imem_addr); end
    checks++; if (o_ins !== 32'hC0DE_0000) begin errors++; $display("FAIL o_ins_pass: got %h exp c0de0000", o_ins); end
  endtask

  task automatic test_seq();
    tick();
    checks++; if (o_imem_addr !== 32'h4) begin errors++; $display("FAIL seq_addr4: got %h exp 00000004", o_imem_addr); end
    checks++; if (o_id_valid !== 1'b1 || o_id_pc !== 32'h0 || o_id_ins !== 32'hC0DE_0000) begin errors++; $display("FAIL seq_id0: got v=%b pc=%h ins=%h exp v=1 pc=00000000 ins=c0de0000", o_id_valid, o_id_pc, o_id_ins); end
    tick();
    checks++; if (o_imem_addr !== 32'h8 || o_id_pc !== 32'h4) begin errors++; $display("FAIL seq_step2: got addr=%h idpc=%h exp 00000008 00000004", o_imem_addr, o_id_pc); end
    tick();
    checks++; if (o_imem_addr !== 32'hC || o_id_pc !== 32'h8 || o_id_ins !== 32'hC0DE_0008) begin errors++; $display("FAIL seq_step3: got addr=%h idpc=%h ins=%h exp 0000000c 00000008 c0de0008", o_imem_addr, o_id_pc, o_id_ins); end
  endtask

  task automatic test_cold_branch();
    tick();
    checks++; if (o_imem_addr !== 32'h10) begin errors++; $display("FAIL cold_reach: got %h exp 00000010", o_imem_addr); end
    i_br = 1; i_imm = 32'd8;
    tick();
    checks++; if (o_imem_addr !== 32'h14 || o_id_pred_taken !== 1'b0) begin errors++; $display("FAIL cold_nt: got addr=%h pred=%b exp 00000014 0", o_imem_addr, o_id_pred_taken); end
    i_br = 0; i_imm = 32'd4;
    i_id_stall = 1; i_ex_upd = 1; i_ex_pc = 32'h10; i_ex_taken = 1;
    tick();
    tick();
    checks++; if (o_imem_addr !== 32'h14 || o_id_pc !== 32'h10 || o_id_valid !== 1'b1) begin errors++; $display("FAIL cold_hold: got addr=%h idpc=%h v=%b exp 00000014 00000010 1", o_imem_addr, o_id_pc, o_id_valid); end
    i_ex_upd = 0; i_id_stall = 0;
    i_redirect = 1; i_redirect_pc = 32'h10;
    tick();
    checks++; if (o_imem_addr !== 32'h10 || o_id_valid !== 1'b0) begin errors++; $display("FAIL cold_redirect: got addr=%h v=%b exp 00000010 0", o_imem_addr, o_id_valid); end
    i_redirect = 0; i_br = 1; i_imm = 32'd8;
    tick();
    checks++; if (o_imem_addr !== 32'h18 || o_id_pred_taken !== 1'b1 || o_id_pc !== 32'h10) begin errors++; $display("FAIL warm_taken: got addr=%h pred=%b idpc=%h exp 00000018 1 00000010", o_imem_addr, o_id_pred_taken, o_id_pc); end
    i_br = 0; i_imm = 32'd4;
  endtask

  task automatic test_wrap();
    i_ex_upd = 1; i_ex_pc = 32'h20; i_ex_taken = 1; i_redirect = 1; i_redirect_pc = 32'h20;
    tick();
    i_redirect = 0; i_id_stall = 1;
    tick();
    i_ex_upd = 0; i_id_stall = 0; i_br = 1; i_imm = 32'hFFFF_FFF0;
    tick();
    checks++; if (o_imem_addr !== 32'h10 || o_id_pred_taken !== 1'b1 || o_id_pc !== 32'h20) begin errors++; $display("FAIL wrap: got addr=%h pred=%b idpc=%h exp 00000010 1 00000020", o_imem_addr, o_id_pred_taken, o_id_pc); end
    i_br = 0; i_imm = 32'd4;
  endtask

  task automatic fetch_30(input logic upd, input logic [31:0] exp_addr, input logic exp_pred, input string name);
    i_redirect = 1; i_redirect_pc = 32'h30;
    tick();
    i_redirect = 0; i_br = 1; i_imm = 32'h40;
    i_ex_upd = upd; i_ex_pc = 32'h30; i_ex_taken = 0;
    tick();
    checks++; if (o_imem_addr !== exp_addr || o_id_pred_taken !== exp_pred) begin errors++; $display("FAIL %s: got addr=%h pred=%b exp %h %b", name, o_imem_addr, o_id_pred_taken, exp_addr, exp_pred); end
    i_br = 0; i_imm = 32'd4; i_ex_upd = 0;
  endtask

  task automatic test_saturation();
    i_id_stall = 1; i_ex_upd = 1; i_ex_pc = 32'h30; i_ex_taken = 0;
    repeat (3) tick();
    i_ex_upd = 0; i_id_stall = 0;
    fetch_30(0, 32'h34, 0, "sat_low");
    i_id_stall = 1; i_ex_upd = 1; i_ex_pc = 32'h30; i_ex_taken = 1;
    repeat (4) tick();
    i_ex_upd = 0; i_id_stall = 0;
    fetch_30(0, 32'h70, 1, "sat_high");
    fetch_30(1, 32'h70, 1, "same_cycle_11");
    fetch_30(1, 32'h70, 1, "same_cycle_10");
    fetch_30(0, 32'h34, 0, "after_two_nt");
  endtask

  task automatic test_redirect_stall();
    i_imem_stall = 1; i_redirect = 1; i_redirect_pc = 32'h100;
    tick();
    checks++; if (o_imem_addr !== 32'h34 || o_id_valid !== 1'b0) begin errors++; $display("FAIL rs_c1: got addr=%h v=%b exp 00000034 0", o_imem_addr, o_id_valid); end
    i_redirect_pc = 32'h200;
    tick();
    i_redirect = 0;
    tick();
    checks++; if (o_imem_addr !== 32'h34 || o_id_valid !== 1'b0) begin errors++; $display("FAIL rs_c3: got addr=%h v=%b exp 00000034 0", o_imem_addr, o_id_valid); end
    i_imem_stall = 0;
    tick();
    checks++; if (o_imem_addr !== 32'h200 || o_id_valid !== 1'b0) begin errors++; $display("FAIL rs_release: got addr=%h v=%b exp 00000200 0", o_imem_addr, o_id_valid); end
    tick();
    checks++; if (o_imem_addr !== 32'h204 || o_id_valid !== 1'b1 || o_id_pc !== 32'h200 || o_id_ins !== 32'hC0DE_0200) begin errors++; $display("FAIL rs_arrive: got addr=%h v=%b idpc=%h ins=%h exp 00000204 1 00000200 c0de0200", o_imem_addr, o_id_valid, o_id_pc, o_id_ins); end
  endtask

  task automatic test_hazard();
    i_id_stall = 1;
    repeat (2) begin
      tick();
      checks++; if (o_imem_addr !== 32'h204 || o_id_valid !== 1'b1 || o_id_pc !== 32'h200 || o_id_ins !== 32'hC0DE_0200) begin errors++; $display("FAIL hz_hold: got addr=%h v=%b idpc=%h ins=%h exp 00000204 1 00000200 c0de0200", o_imem_addr, o_id_valid, o_id_pc, o_id_ins); end
    end
    i_id_stall = 0;
    tick();
    checks++; if (o_imem_addr !== 32'h208 || o_id_pc !== 32'h204) begin errors++; $display("FAIL hz_release: got addr=%h idpc=%h exp 00000208 00000204", o_imem_addr, o_id_pc); end
    i_imem_stall = 1;
    tick();
    checks++; if (o_imem_addr !== 32'h208 || o_id_valid !== 1'b0 || o_id_pc !== 32'h204) begin errors++; $display("FAIL bubble: got addr=%h v=%b idpc=%h exp 00000208 0 00000204", o_imem_addr, o_id_valid, o_id_pc); end
    i_imem_stall = 0;
    tick();
    checks++; if (o_imem_addr !== 32'h20C || o_id_valid !== 1'b1 || o_id_pc !== 32'h208) begin errors++; $display("FAIL bubble_end: got addr=%h v=%b idpc=%h exp 0000020c 1 00000208", o_imem_addr, o_id_valid, o_id_pc); end
  endtask

  task automatic test_async_reset();
    i_imem_stall = 1; i_redirect = 1; i_redirect_pc = 32'h300;
    tick();
    i_redirect = 0;
    rst_n = 0;
    #2;
    checks++; if (o_imem_req !== 1'b0 || o_imem_addr !== 32'h0 || o_id_valid !== 1'b0 || o_id_pc !== 32'h0 || o_id_ins !== 32'h0 || o_id_pred_taken !== 1'b0) begin errors++; $display("FAIL async_rst: got req=%b addr=%h v=%b idpc=%h ins=%h pred=%b exp all zero", o_imem_req, o_imem_addr, o_id_valid, o_id_pc, o_id_ins, o_id_pred_taken); end
    i_imem_stall = 0;
    tick();
    rst_n = 1;
    tick();
    checks++; if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0) begin errors++; $display("FAIL restart: got req=%b addr=%h exp 1 00000000", o_imem_req, o_imem_addr); end
    tick();
    checks++; if (o_imem_addr !== 32'h4 || o_id_pc !== 32'h0 || o_id_valid !== 1'b1) begin errors++; $display("FAIL restart_fetch: got addr=%h idpc=%h v=%b exp 00000004 00000000 1", o_imem_addr, o_id_pc, o_id_valid); end
  endtask

  initial begin
    test_reset();
    test_seq();
    test_cold_branch();
    test_wrap();
    test_saturation();
    test_redirect_stall();
    test_hazard();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_predict.md
# fetch_predict

Instruction-fetch stage for the pipelined RV32I core. It owns the PC and drives the instruction-memory port. It forwards each returned word to the branch predecoder and uses the predecoder's branch flag and offset, together with a 2-bit saturating branch history table (BHT), to pick the next PC. Fetched instructions go into the IF/ID pipeline register. Execute-stage redirects and BHT updates feed back into this block.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BHT_IDX, 4, BHT index width; table holds 2^BHT_IDX entries, indexed by PC[BHT_IDX+1:2]

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- o_imem_req  out  1  instruction-memory request
- o_imem_addr  out  32  fetch address, equal to current PC
- i_imem_stall  in  1  memory not ready; i_imem_rdata invalid this cycle
- i_imem_rdata  in  32  instruction word, valid when o_imem_req=1 and i_imem_stall=0
- o_ins  out  32  combinational copy of i_imem_rdata, sent to predecoder
- i_br  in  1  predecoder: o_ins is a conditional branch
- i_imm  in  32  predecoder: sign-extended branch offset if i_br=1, else 32'd4
- i_id_stall  in  1  downstream hazard; hold PC and IF/ID register
- i_redirect  in  1  execute-stage mispredict; flush and refetch
- i_redirect_pc  in  32  correct target PC
- i_ex_upd  in  1  resolved conditional branch in execute; update BHT
- i_ex_pc  in  32  PC of the resolved branch
- i_ex_taken  in  1  actual branch outcome
- o_id_valid  out  1  IF/ID register holds a valid instruction
- o_id_ins  out  32  IF/ID instruction
- o_id_pc  out  32  IF/ID PC
- o_id_pred_taken  out  1  prediction applied to this instruction

## Operation
- Predict taken when `ctr[1]=1`, where `ctr` is the BHT entry at index PC[BHT_IDX+1:2].
- Next-PC candidate: `npc = pc + ((i_br && ctr[1]) ? i_imm : 32'd4)`. Addition is modulo 2^32, so negative offsets wrap naturally.
- Fetch completes (the "fire" condition) when `o_imem_req=1 && !i_imem_stall && !i_id_stall && !pend && !i_redirect`.
- Per-cycle priority: reset > i_redirect > pending redirect > stall > fire.
- **i_redirect=1:**
  - If i_imem_stall=0: pc <= i_redirect_pc.
  - If i_imem_stall=1: the memory address must stay stable, so latch pend_pc <= i_redirect_pc and set pend <= 1.
  - In both cases o_id_valid <= 0.
- **pend=1 and i_imem_stall=0:** pc <= pend_pc, pend <= 0, o_id_valid <= 0. The word returned this cycle is discarded.
- **Newer redirect while pend=1:** overwrites pend_pc; the latest redirect wins.
- **Fire:**
  - pc <= npc.
  - o_id_ins <= i_imem_rdata, o_id_pc <= pc, o_id_pred_taken <= i_br && ctr[1], o_id_valid <= 1.
- **i_id_stall=1 (no redirect):** pc and all o_id_* hold. The memory word is ignored and is refetched once the stall releases.
- **i_imem_stall=1 (no i_id_stall, no redirect):** pc holds. o_id_valid <= 0 (bubble). o_id_ins, o_id_pc and o_id_pred_taken hold.
- **BHT update on i_ex_upd:** entry at i_ex_pc[BHT_IDX+1:2] saturating-increments if i_ex_taken, else saturating-decrements (11 stays 11 on taken; 00 stays 00 on not-taken).
  - Independent of stalls and redirects.
- **Same-entry read and update in one cycle:** prediction uses the old value (no bypass).
- **BHT aliasing:** no tags; aliasing is accepted.

## Timing
- **Reset values:**
  - pc = RESET_PC, pend = 0, pend_pc = 0.
  - All BHT entries = 2'b01 (weakly not-taken).
  - o_imem_req = 0, o_id_valid = 0, o_id_ins = 0, o_id_pc = 0, o_id_pred_taken = 0.
- o_imem_req is registered. It rises on the first clock edge after rst_n deasserts and stays 1 until the next reset.
- o_imem_addr and o_ins are combinational from pc and i_imem_rdata. The predecoder path is in the same cycle.
- Fetch latency is 1 cycle: the word accepted at edge N appears on o_id_* after edge N.
- Back-to-back fetch sustains one instruction per cycle.
- Redirect penalty: with memory ready, the first correct-path instruction reaches IF/ID 2 edges after the i_redirect cycle. With memory stalled, it arrives 2 edges after the stall clears.
- A BHT update issued at edge N affects predictions from cycle N+1.
- Reset asserted mid-operation clears all state immediately, including pending redirects and any in-flight fetch.

## Test plan
- **Sequential fetch:** reset, memory ready, i_br=0 -> o_imem_addr 0x0, 0x4, 0x8. o_id_pc follows one cycle later with o_id_valid=1.
- **Cold branch:** branch at 0x10 with i_imm=8, BHT reset -> next addr 0x14, o_id_pred_taken=0. Then two i_ex_upd taken for pc 0x10 (counter 11) and refetch 0x10 -> next addr 0x18, o_id_pred_taken=1.
- **Backward wrap:** pc 0x20, i_imm=0xFFFF_FFF0, counter 11 -> next addr 0x10.
- **Saturation:** three not-taken updates from 01 -> counter stays 00. Four taken updates -> stays 11. Update and fetch of the same index in one cycle -> prediction uses the old value.
- **Redirect under stall:** i_imem_stall=1 for 3 cycles, i_redirect to 0x100 in cycle 1 and 0x200 in cycle 2 -> o_imem_addr holds until the stall drops, then 0x200. o_id_valid stays 0 and the stale word is dropped.
- **Hazard and reset:** i_id_stall=1 for 2 cycles -> o_id_* and pc unchanged. rst_n pulsed low mid-stream -> all outputs return to reset values asynchronously, fetch restarts at RESET_PC.
